// File: rtl/mem_arbiter.sv
// Two-requester arbiter (core / loader) for one unified memory port.
// Optional round-robin tie-break: define MEM_ARB_RR_EN (default: core wins ties).
module mem_arbiter #(
    parameter int N      = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         core_req,
    input  logic         core_we,
    input  logic [N-1:0] core_addr,
    input  logic [N-1:0] core_wdata,
    output logic         core_gnt,
    output logic         core_rvalid,
    output logic [N-1:0] core_rdata,
    input  logic         ldr_req,
    input  logic         ldr_we,
    input  logic [N-1:0] ldr_addr,
    input  logic [N-1:0] ldr_wdata,
    output logic         ldr_gnt,
    output logic         ldr_rvalid,
    output logic [N-1:0] ldr_rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RWAIT
    } state_t;

    localparam logic       CORE = 1'b0;
    localparam logic       LDR  = 1'b1;
    localparam logic [1:0] LAT  = 2'(RD_LAT);

    state_t     state;
    logic       owner;
    logic       we_q;
    logic [1:0] cnt;
    logic       any_req;
    logic       win;

`ifdef MEM_ARB_RR_EN
    logic       last_owner;
`endif

    assign any_req = core_req | ldr_req;

    // Tie-break only matters when both requesters ask in the same IDLE cycle.
    always_comb begin
        win = CORE;
        if (core_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
            win = (last_owner == LDR) ? CORE : LDR;
`else
            win = CORE;
`endif
        end else if (ldr_req) begin
            win = LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            owner       <= CORE;
            we_q        <= 1'b0;
            core_gnt    <= 1'b0;
            ldr_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            ldr_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ldr_rdata   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner  <= LDR;
`endif
        end else begin
            core_gnt    <= 1'b0;
            ldr_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            ldr_rvalid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= win;
                        we_q      <= (win == LDR) ? ldr_we : core_we;
                        mem_addr  <= (win == LDR) ? ldr_addr : core_addr;
                        mem_wdata <= (win == LDR) ? ldr_wdata : core_wdata;
                        core_gnt  <= (win == CORE);
                        ldr_gnt   <= (win == LDR);
`ifdef MEM_ARB_RR_EN
                        last_owner <= win;
`endif
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= LAT;
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        if (owner == LDR) begin
                            ldr_rdata  <= mem_rdata;
                            ldr_rvalid <= 1'b1;
                        end else begin
                            core_rdata  <= mem_rdata;
                            core_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobe gated by rst so a reset cycle can never write memory.
    assign mem_we = (state == XFER) & we_q & ~rst;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT = 2).
// Memory model: two-stage read pipeline, so data is valid 2 cycles after address.
module tb_mem_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req, core_we;
    logic [N-1:0] core_addr, core_wdata;
    logic         core_gnt, core_rvalid;
    logic [N-1:0] core_rdata;
    logic         ldr_req, ldr_we;
    logic [N-1:0] ldr_addr, ldr_wdata;
    logic         ldr_gnt, ldr_rvalid;
    logic [N-1:0] ldr_rdata;
    logic         mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.N(N), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .ldr_rdata(ldr_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [N-1:0] wr_mem [64];
    bit           wr_ok  [64];
    logic [N-1:0] d1, d2;
    bit           we_seen = 1'b0;

    function automatic logic [N-1:0] init_word(input logic [5:0] idx);
        if (idx == 6'd8) return 32'h1234_5678;
        return {16'hC0DE, 10'd0, idx};
    endfunction

    function automatic logic [N-1:0] rd_word(input logic [5:0] idx);
        return wr_ok[idx] ? wr_mem[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            wr_mem[mem_addr[7:2]] <= mem_wdata;
            wr_ok[mem_addr[7:2]]  <= 1'b1;
        end
        d1 <= rd_word(mem_addr[7:2]);
        d2 <= d1;
    end
    assign mem_rdata = d2;

    always @(negedge clk) if (rst && mem_we) we_seen = 1'b1;

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int gord[$];
    int rord[$];
    int both;
    logic [N-1:0] eo;

    initial begin
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 32'h40; core_wdata = 32'hFFFF_FFFF;
        ldr_req = 1'b1; ldr_we = 1'b1;
        ldr_addr = 32'h44; ldr_wdata = 32'hEEEE_EEEE;

        // Reset with pending write requests.
        cyc();
        cyc();
        check("rst_gnt", {core_gnt, ldr_gnt}, 0);
        check("rst_rvalid", {core_rvalid, ldr_rvalid}, 0);
        check("rst_memwe", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", core_rdata | ldr_rdata, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwdata", mem_wdata, 0);
        rst = 1'b0; core_req = 1'b0; ldr_req = 1'b0;
        cyc();
        check("rst_idle", busy, 0);
        check("rst_no_we", we_seen, 0);

        // Continuous read contention, core 0x0 vs loader 0x20.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (core_gnt && ldr_gnt) both++;
            if (core_rvalid && ldr_rvalid) both++;
            if (core_gnt) gord.push_back(0);
            if (ldr_gnt) gord.push_back(1);
            if (core_rvalid) rord.push_back(0);
            if (ldr_rvalid) rord.push_back(1);
            if (gord.size() >= 4) begin
                core_req = 1'b0; ldr_req = 1'b0;
            end
        end
        check("cont_ngnt", gord.size(), 4);
        check("cont_nrv", rord.size(), 4);
        check("cont_both", both, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            eo = i % 2;
`else
            eo = 0;
`endif
            check($sformatf("cont_g%0d", i), (i < gord.size()) ? gord[i] : 7, eo);
            check($sformatf("cont_r%0d", i), (i < rord.size()) ? rord[i] : 7, eo);
        end
        check("cont_cdata", core_rdata, 32'hC0DE_0000);
`ifdef MEM_ARB_RR_EN
        check("cont_ldata", ldr_rdata, 32'h1234_5678);
`else
        check("cont_ldata", ldr_rdata, 0);
`endif
        check("cont_idle", busy, 0);

        // Lone core write.
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        cyc();
        check("wr_gnt", {core_gnt, ldr_gnt}, 2'b10);
        check("wr_memwe", mem_we, 1);
        check("wr_maddr", mem_addr, 32'h10);
        check("wr_mwdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_busy1", busy, 1);
        core_req = 1'b0;
        cyc();
        check("wr_busy2", busy, 0);
        check("wr_memwe2", mem_we, 0);
        check("wr_stored", rd_word(6'd4), 32'hDEAD_BEEF);

        // Loader read at 0x20.
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
        cyc();
        check("lr_gnt", {core_gnt, ldr_gnt}, 2'b01);
        check("lr_memwe", mem_we, 0);
        ldr_req = 1'b0;
        cyc();
        check("lr_t2", {ldr_gnt, ldr_rvalid, busy}, 3'b001);
        cyc();
        check("lr_t3", {ldr_rvalid, busy}, 2'b01);
        cyc();
        check("lr_rvalid", {ldr_rvalid, core_rvalid, busy}, 3'b100);
        check("lr_rdata", ldr_rdata, 32'h1234_5678);
        cyc();
        check("lr_pulse", ldr_rvalid, 0);
        check("lr_hold", ldr_rdata, 32'h1234_5678);

        // Back-to-back core reads 0x0 then 0x4.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
        cyc();
        check("bb_gnt1", core_gnt, 1);
        core_req = 1'b0;
        cyc();
        cyc();
        check("bb_norv", core_rvalid, 0);
        cyc();
        check("bb_rv1", core_rvalid, 1);
        check("bb_d1", core_rdata, 32'hC0DE_0000);
        core_req = 1'b1; core_addr = 32'h4;
        cyc();
        check("bb_gnt2", {core_gnt, core_rvalid}, 2'b10);
        core_req = 1'b0;
        cyc();
        cyc();
        cyc();
        check("bb_rv2", core_rvalid, 1);
        check("bb_d2", core_rdata, 32'hC0DE_0001);
        check("bb_lhold", ldr_rdata, 32'h1234_5678);

        // Reset during RWAIT of a core read.
        core_req = 1'b1; core_addr = 32'h10;
        cyc();
        check("rr_gnt", core_gnt, 1);
        core_req = 1'b0;
        cyc();
        check("rr_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rr_norv", core_rvalid, 0);
        check("rr_rdata", core_rdata, 0);
        check("rr_idle", busy, 0);
        both = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (core_rvalid || busy) both++;
        end
        check("rr_quiet", both, 0);
        core_req = 1'b1; core_addr = 32'h20;
        cyc();
        check("rr_gnt2", core_gnt, 1);
        core_req = 1'b0;
        cyc();
        cyc();
        check("rr_early", core_rvalid, 0);
        cyc();
        check("rr_rv2", core_rvalid, 1);
        check("rr_d2", core_rdata, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified memory port of the multicycle MIPS system. It shares memory between the `mips_core` and a program loader/DMA requester. It serialises their read and write requests and sequences the memory's fixed read latency. Each requester gets a one-cycle grant pulse and, for reads, a one-cycle `rvalid` pulse with registered read data.

## Interface
- `N`, 32, address and data width
- `RD_LAT`, 1, memory read latency in cycles from address presented to `mem_rdata` valid; legal range 1..3
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset; one clock, and reset is synchronous and active-high
- `core_req`, `core_we`  in  1  core request and write-enable
- `core_addr`, `core_wdata`  in  N  core address and write data
- `core_gnt`  out  1  one-cycle pulse: core request accepted and issued
- `core_rvalid`  out  1  one-cycle pulse: `core_rdata` valid
- `core_rdata`  out  N  registered read data for the core
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: same as the core set, for the loader
- `mem_we`  out  1  memory write strobe
- `mem_addr`, `mem_wdata`  out  N  registered memory address and write data
- `mem_rdata`  in  N  memory read data
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states are IDLE, XFER and RWAIT. Reset state is IDLE.
- **IDLE**
  - Requests are sampled only in IDLE.
  - If any `req` is high, arbitrate and latch the winner's `we`, `addr` and `wdata` into `owner`, `mem_addr` and `mem_wdata`, then go to XFER.
  - With no request, stay in IDLE; `mem_addr` and `mem_wdata` hold their values.
- **XFER** lasts exactly one cycle.
  - The owner's `gnt` is high.
  - `mem_we` = latched `we` AND NOT `rst`.
  - For a write, go to IDLE. For a read, load the latency counter with `RD_LAT` and go to RWAIT.
- **RWAIT**
  - `mem_addr` is held. The counter decrements each cycle.
  - In the cycle the counter equals 1, capture `mem_rdata` into the owner's `rdata` register, set the owner's `rvalid`, and go to IDLE.
- The `rvalid` pulse appears in the following IDLE cycle. A new request may be sampled in that same cycle.
- `rdata` registers hold their value until the next read completes for the same requester.
- **Arbitration**
  - A single requester always wins.
  - On a tie, the winner is set by Configuration. `owner` is recorded in `last_owner`.
- **Requester rules**
  - `req`, `we`, `addr` and `wdata` stay stable until `gnt`.
  - After `gnt`, the requester may drop `req` or present a new request.
  - A request withdrawn before being sampled in IDLE is never issued.
  - `req` is ignored outside IDLE.
- **Reset** (sampled at any edge)
  - Next state is IDLE and the counter is cleared.
  - All `gnt` and `rvalid` outputs go to 0. `rdata`, `mem_addr` and `mem_wdata` go to 0. `last_owner` is set to loader.
  - A transaction in flight is dropped with no `rvalid`.
  - `mem_we` is forced low combinationally while `rst` is high, so no write is issued during a reset cycle.
- Reset values: `core_gnt`, `ldr_gnt`, `core_rvalid`, `ldr_rvalid`, `mem_we` and `busy` are 0. `core_rdata`, `ldr_rdata`, `mem_addr` and `mem_wdata` are 0.

## Timing
- Request sampled in IDLE at cycle t.
  - `gnt` and the memory command appear in cycle t+1.
  - For a write, memory is written at the end of t+1 and the arbiter is back in IDLE at t+2.
  - For a read, `mem_rdata` is captured at the end of cycle t+1+`RD_LAT` and `rvalid` is high in cycle t+2+`RD_LAT`.
- Throughput: one write every 2 cycles; one read every `RD_LAT`+2 cycles.
- `gnt` and `rvalid` are each exactly one cycle wide. They are never high for both requesters in the same cycle.
- `busy` is high from t+1 through the last RWAIT cycle.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- **Defined:** round-robin on a tie; the requester that is not `last_owner` wins. Because `last_owner` resets to loader, the core wins the first tie. With continuous contention, grants alternate.
- **Undefined:** fixed priority; the core always wins a tie. The loader can be starved, and this is accepted behaviour.

## Test plan
- **Reset with pending requests:** hold `rst` high 2 cycles with both `req` high and `we`=1. Required: all outputs are 0, `mem_we` is never high, and state is IDLE after release.
- **Lone core write:** `core_req`, `we`=1, `addr`=0x10, `wdata`=0xDEADBEEF, sampled at t. Required: `core_gnt`, `mem_we` and `mem_addr`=0x10 / `mem_wdata`=0xDEADBEEF in cycle t+1; `busy` is 0 at t+2.
- **Loader read, `RD_LAT`=2:** `ldr` reads `addr`=0x20 and memory returns 0x12345678. Required: `ldr_gnt` at t+1; `ldr_rvalid`=1 with `ldr_rdata`=0x12345678 at t+4; `core_rvalid` stays 0.
- **Continuous contention:** both requesters read every opportunity. Required: with `MEM_ARB_RR_EN`, the grant order is core, ldr, core, ldr. Without it, the order is core, core, core.
- **Reset during RWAIT:** assert `rst` during RWAIT of a core read. Required: no `core_rvalid`, `core_rdata`=0, and the next core read completes normally with the correct latency.
- **Back-to-back core reads:** core reads 0x0 then 0x4, with the second request presented in the `rvalid` cycle. Required: the second `core_gnt` arrives the cycle after the first `core_rvalid`, and both data words are correct.
